noc_receiver: RTL and testbench
===============================

Name: noc_receiver

Overview:
Downstream consumer of the node transceiver's fan-out bus. Accepts flits from PORTS_NUM+1 input channels (neighbour ports 0..PORTS_NUM-1, local port PORTS_NUM). Uses round-robin arbitration to pick one channel per cycle, and writes the winning flit through a one-stage output register into the node FIFO's write side. The FIFO's read side feeds the transceiver.

Parameters:
DATA_SIZE, 4, payload width in bits
ADDR_SIZE, 1, destination address field width in bits
PORTS_NUM, 4, number of neighbour ports; total channels = PORTS_NUM+1
BUS_SIZE (localparam), DATA_SIZE+ADDR_SIZE+1, flit width

Ports:
clk  in  1  clock, all state on rising edge
a_rst  in  1  reset, asynchronous, active-low
data_i  in  BUS_SIZE*(PORTS_NUM+1)  channel i at data_i[i*BUS_SIZE +: BUS_SIZE]
r_ready_out  out  PORTS_NUM+1  one-hot accept strobe per channel, or all zero
full  in  1  FIFO has no free slot
almost_full  in  1  FIFO has exactly one free slot
w_req  out  1  FIFO write strobe
data_o  out  BUS_SIZE  flit to FIFO, valid while w_req=1

Behaviour:
- Flit format: bit BUS_SIZE-1 = valid, next ADDR_SIZE bits = address, low DATA_SIZE bits = payload. A channel requests when its valid bit is 1. The address is not inspected; every valid flit is stored.
- Handshake: a sender holds its flit stable until it sees its r_ready_out bit high. A transfer on channel i occurs at a rising edge where valid_i=1 and r_ready_out[i]=1. The sender may change data in the following cycle.
- Space rule: space = !full && !(w_req && almost_full). The second term covers a write already registered but not yet reflected in the FIFO's full flag.
- Arbitration is combinational from the registered pointer ptr (0..PORTS_NUM). Grant goes to the first valid channel found scanning ptr, ptr+1, ..., wrapping modulo PORTS_NUM+1.
- r_ready_out is the one-hot grant when space=1 and any channel is valid; otherwise it is all zero. At most one bit is ever high.
- On a transfer from channel g: ptr <= (g==PORTS_NUM) ? 0 : g+1; data_o <= flit of g; w_req <= 1.
- With no transfer: ptr is held and w_req <= 0. data_o holds its last value.
- Latency: the flit is on data_o with w_req=1 exactly one cycle after its accept edge. Sustained throughput is 1 flit/cycle while space=1.
- Channels with valid=0 never get a grant, regardless of the rest of their bus contents.
- Reset (a_rst=0, any time, including mid-transfer): ptr=0, w_req=0, data_o=0 immediately. r_ready_out is forced to 0 while a_rst=0. A flit registered but not yet written is discarded. The first grant after reset release follows normal rules with ptr=0.
- full and almost_full both high: treated as full, no grant.
- Boundary cases:
  - Single valid channel: granted every cycle while space=1.
  - ptr at PORTS_NUM: wraps to 0.
  - All channels valid: grant order 0,1,...,PORTS_NUM,0,...

Decomposition:
- Shared package/header holds BUS_SIZE and the field offsets (VALID_BIT, ADDR_LSB, DATA_LSB). The transceiver and FIFO reuse these.
- One sub-module: rr_arbiter, parameterised on N. Inputs: req[N-1:0], ptr, enable. Output: one-hot grant[N-1:0] plus the encoded grant index. It is purely combinational.
- noc_receiver holds ptr, the output register, the space logic and the mux.

Test Plan (DATA_SIZE=4, ADDR_SIZE=1, PORTS_NUM=4, BUS_SIZE=6):
- Reset: a_rst=0 with channels 1 and 3 valid -> r_ready_out=00000, w_req=0, data_o=000000. Release reset -> r_ready_out=00010 in the same cycle; the next cycle gives w_req=1 and data_o = channel 1's flit.
- Round-robin: all 5 channels valid and held, full=0 -> grant sequence 00001,00010,00100,01000,10000,00001. w_req stays high continuously, and data_o follows one cycle behind each grant.
- Single requester: only channel 4 (local) valid, payload 1010, addr 1 -> r_ready_out=10000 every cycle. data_o=111010, ptr toggles 0 on each transfer.
- Back-pressure: full=1 with channels valid -> r_ready_out=00000 and w_req falls to 0 next cycle. Then drop full and raise almost_full while a write is pending (w_req=1) -> still no grant that cycle. The following cycle (w_req=0, almost_full=1) -> one grant, then stall.
- Invalid flit: channel 2 bus = 0_1_1111 (valid=0) and all others idle -> r_ready_out=00000, w_req=0, ptr unchanged.
- Reset mid-transfer: assert a_rst=0 on the cycle after an accept -> w_req=0 and data_o=000000 immediately, with no FIFO write for that flit.

Source files
------------

// File: rtl/noc_receiver_pkg.sv
// Shared definitions for the NoC node: flit layout helpers and default sizing.
// The transceiver and the node FIFO import the same package, so all three
// blocks agree on where the valid, address and payload fields sit.
package noc_receiver_pkg;

    // Default node configuration.
    localparam int DEF_DATA_SIZE = 4;
    localparam int DEF_ADDR_SIZE = 1;
    localparam int DEF_PORTS_NUM = 4;

    // Payload always starts at bit 0 of a flit.
    localparam int DATA_LSB = 0;

    // Flit width: valid bit on top, then address, then payload.
    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    // Position of the valid bit (MSB of the flit).
    function automatic int valid_bit(input int data_size, input int addr_size);
        return data_size + addr_size;
    endfunction

    // Address field sits directly above the payload.
    function automatic int addr_lsb(input int data_size);
        return data_size;
    endfunction

    // Width of an index able to address n channels (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Layout for the default configuration.
    localparam int DEF_BUS_SIZE  = bus_size(DEF_DATA_SIZE, DEF_ADDR_SIZE);
    localparam int DEF_VALID_BIT = valid_bit(DEF_DATA_SIZE, DEF_ADDR_SIZE);
    localparam int DEF_ADDR_LSB  = addr_lsb(DEF_DATA_SIZE);

endpackage

// File: rtl/noc_receiver_rr_arbiter.sv
// Combinational round-robin arbiter. Scans requests starting at ptr_i and
// wrapping modulo N; the first requester found wins. With enable_i low no
// grant is issued at all (the index output is then don't-care, driven 0).
module rr_arbiter
    import noc_receiver_pkg::*;
#(
    parameter int N     = DEF_PORTS_NUM + 1,
    parameter int PTR_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             enable_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o
);

    // Priority scan from the pointer; a single subtract gives the wrap
    // because the pointer never exceeds N-1.
    always_comb begin
        int   c;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        c           = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (enable_i && !found && c < N && req_i[c]) begin
                found       = 1'b1;
                grant_o[c]  = 1'b1;
                grant_idx_o = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/noc_receiver.sv
// NoC receiver: arbitrates PORTS_NUM neighbour channels plus the local
// channel into the node FIFO. One flit per cycle is accepted while the FIFO
// has room; the winner goes through a single output register to the FIFO.
module noc_receiver
    import noc_receiver_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int PORTS_NUM = DEF_PORTS_NUM
) (
    input  logic                                                   clk,
    input  logic                                                   a_rst,
    input  logic [bus_size(DATA_SIZE, ADDR_SIZE)*(PORTS_NUM+1)-1:0] data_i,
    output logic [PORTS_NUM:0]                                     r_ready_out,
    input  logic                                                   full,
    input  logic                                                   almost_full,
    output logic                                                   w_req,
    output logic [bus_size(DATA_SIZE, ADDR_SIZE)-1:0]              data_o
);

    localparam int BUS_SIZE  = bus_size(DATA_SIZE, ADDR_SIZE);
    localparam int VALID_BIT = valid_bit(DATA_SIZE, ADDR_SIZE);
    localparam int NCH       = PORTS_NUM + 1;
    localparam int PTR_W     = idx_width(NCH);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(PORTS_NUM);

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                w_req_q, w_req_d;
    logic [BUS_SIZE-1:0] data_q, data_d;

    logic [NCH-1:0]      req;
    logic [NCH-1:0]      grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                space;
    logic                arb_en;
    logic                xfer;
    logic [BUS_SIZE-1:0] flit_sel;

    // A channel requests purely on its valid bit; address is ignored here.
    for (genvar c = 0; c < NCH; c++) begin : g_req
        assign req[c] = data_i[c*BUS_SIZE + VALID_BIT];
    end

    // A write already sitting in the output register will consume the last
    // free slot, so almost_full blocks while that write is still pending.
    assign space  = !full && !(w_req_q && almost_full);
    // Reset gates the arbiter so no sender sees a ready strobe while held.
    assign arb_en = space && a_rst;

    rr_arbiter #(
        .N     (NCH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .enable_i    (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign r_ready_out = grant;
    assign xfer        = |grant;

    // One-hot AND-OR mux selecting the granted channel's flit.
    always_comb begin
        flit_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            flit_sel = flit_sel | ({BUS_SIZE{grant[c]}} & data_i[c*BUS_SIZE +: BUS_SIZE]);
        end
    end

    // Next state: on a transfer advance the pointer past the winner and load
    // the flit; otherwise hold pointer and data and drop the write strobe.
    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        w_req_d = 1'b0;
        if (xfer) begin
            ptr_d   = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            data_d  = flit_sel;
            w_req_d = 1'b1;
        end
    end

    // State registers; reset drops any flit not yet written to the FIFO.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            ptr_q   <= '0;
            w_req_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            w_req_q <= w_req_d;
            data_q  <= data_d;
        end
    end

    assign w_req  = w_req_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_noc_receiver.sv
// Bench for noc_receiver (DATA_SIZE=4, ADDR_SIZE=1, PORTS_NUM=4): hand
// sequences for reset corners, a directed vector table, then randomized
// traffic against a queue-free behavioural model of the arbitration rules.
module tb_noc_receiver;

    localparam int NCH = 5;
    localparam int BW  = 6;

    logic              clk;
    logic              a_rst;
    logic [NCH*BW-1:0] data_i;
    logic [NCH-1:0]    r_ready_out;
    logic              full;
    logic              almost_full;
    logic              w_req;
    logic [BW-1:0]     data_o;

    int checks = 0;
    int errors = 0;

    noc_receiver #(.DATA_SIZE(4), .ADDR_SIZE(1), .PORTS_NUM(4)) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .data_i      (data_i),
        .r_ready_out (r_ready_out),
        .full        (full),
        .almost_full (almost_full),
        .w_req       (w_req),
        .data_o      (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fixed flit per channel: valid=1, addr=c[0], payload=3c+1.
    function automatic logic [BW-1:0] flit(input int c);
        logic [3:0] p;
        logic       a;
        p = 4'(c * 3 + 1);
        a = c[0];
        return {1'b1, a, p};
    endfunction

    // Drive all channels from a valid mask; idle channels keep their other
    // bits so a cleared valid bit is the only thing that blocks them.
    task automatic set_bus(input logic [NCH-1:0] vmask);
        logic [BW-1:0] b;
        for (int c = 0; c < NCH; c++) begin
            b = flit(c);
            b[BW-1] = vmask[c];
            data_i[c*BW +: BW] = b;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NCH-1:0] vmask;
        logic           full;
        logic           af;
        logic [NCH-1:0] rdy;
        logic           wreq;
        logic [BW-1:0]  data;
    } vec_t;

    vec_t tbl[18];

    // Behavioural model state for the random phase.
    int            m_ptr;
    logic          m_wreq;
    logic [BW-1:0] m_data;
    logic [BW-1:0] snd_flit[NCH];

    initial begin
        // ---------------- reset with channels 1 and 3 valid ----------------
        a_rst = 1'b0; full = 1'b0; almost_full = 1'b0;
        set_bus(5'b01010);
        repeat (2) next_cycle();
        chk("rst_rdy", 32'(r_ready_out), 32'h0);
        chk("rst_wreq", 32'(w_req), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        a_rst = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 32'(r_ready_out), 32'b00010);
        next_cycle();
        chk("rel_wreq", 32'(w_req), 32'h1);
        chk("rel_data", 32'(data_o), 32'(flit(1)));
        // ---------------- reset right after an accept ----------------------
        a_rst = 1'b0;
        #1;
        chk("midrst_wreq", 32'(w_req), 32'h0);
        chk("midrst_data", 32'(data_o), 32'h0);
        chk("midrst_rdy", 32'(r_ready_out), 32'h0);
        next_cycle();
        chk("midrst_nowrite", 32'(w_req), 32'h0);

        // ---------------- directed table from a fresh reset ----------------
        //            vmask    full  af    rdy      wreq  data
        tbl[0]  = '{5'b11111, 1'b0, 1'b0, 5'b00001, 1'b0, 6'h00};
        tbl[1]  = '{5'b11111, 1'b0, 1'b0, 5'b00010, 1'b1, 6'h21};
        tbl[2]  = '{5'b11111, 1'b0, 1'b0, 5'b00100, 1'b1, 6'h34};
        tbl[3]  = '{5'b11111, 1'b0, 1'b0, 5'b01000, 1'b1, 6'h27};
        tbl[4]  = '{5'b11111, 1'b0, 1'b0, 5'b10000, 1'b1, 6'h3A};
        tbl[5]  = '{5'b11111, 1'b0, 1'b0, 5'b00001, 1'b1, 6'h2D};
        tbl[6]  = '{5'b11111, 1'b1, 1'b0, 5'b00000, 1'b1, 6'h21};
        tbl[7]  = '{5'b11111, 1'b0, 1'b1, 5'b00010, 1'b0, 6'h21};
        tbl[8]  = '{5'b11111, 1'b0, 1'b1, 5'b00000, 1'b1, 6'h34};
        tbl[9]  = '{5'b11111, 1'b0, 1'b1, 5'b00100, 1'b0, 6'h34};
        tbl[10] = '{5'b11111, 1'b1, 1'b1, 5'b00000, 1'b1, 6'h27};
        tbl[11] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 6'h27};
        tbl[12] = '{5'b01000, 1'b0, 1'b0, 5'b01000, 1'b0, 6'h27};
        tbl[13] = '{5'b00001, 1'b0, 1'b0, 5'b00001, 1'b1, 6'h3A};
        tbl[14] = '{5'b10000, 1'b0, 1'b0, 5'b10000, 1'b1, 6'h21};
        tbl[15] = '{5'b10000, 1'b0, 1'b0, 5'b10000, 1'b1, 6'h2D};
        tbl[16] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 6'h2D};
        tbl[17] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 6'h2D};
        a_rst = 1'b1;
        for (int r = 0; r < 18; r++) begin
            set_bus(tbl[r].vmask);
            full = tbl[r].full;
            almost_full = tbl[r].af;
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy", r), 32'(r_ready_out), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_wreq", r), 32'(w_req), 32'(tbl[r].wreq));
            chk($sformatf("tbl%0d_data", r), 32'(data_o), 32'(tbl[r].data));
            next_cycle();
        end

        // ---------------- invalid flit on channel 2 (ptr is 0 here) --------
        data_i = '0;
        data_i[2*BW +: BW] = 6'b011111;
        @(negedge clk);
        chk("inv_rdy", 32'(r_ready_out), 32'h0);
        next_cycle();
        chk("inv_wreq", 32'(w_req), 32'h0);
        set_bus(5'b11111);
        @(negedge clk);
        chk("inv_ptr_held", 32'(r_ready_out), 32'b00001);
        next_cycle();

        // ---------------- randomized traffic vs. model ---------------------
        a_rst = 1'b0;
        #1;
        m_ptr = 0; m_wreq = 1'b0; m_data = '0;
        for (int c = 0; c < NCH; c++) snd_flit[c] = 6'(($urandom % 32));
        next_cycle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int            g;
            logic          sp;
            logic [NCH-1:0] exp_rdy;
            a_rst = ($urandom % 80) != 0;
            full = ($urandom % 4) == 0;
            almost_full = ($urandom % 3) == 0;
            // Senders with nothing pending may start a new flit or idle.
            for (int c = 0; c < NCH; c++) begin
                if (!snd_flit[c][BW-1]) begin
                    snd_flit[c] = 6'($urandom);
                    if (($urandom % 3) == 0) snd_flit[c][BW-1] = 1'b0;
                end
                data_i[c*BW +: BW] = snd_flit[c];
            end
            if (!a_rst) begin
                m_ptr = 0; m_wreq = 1'b0; m_data = '0;
            end
            @(negedge clk);
            sp = !full && !(m_wreq && almost_full);
            g = -1;
            if (a_rst && sp) begin
                for (int k = 0; k < NCH; k++) begin
                    if (g < 0 && snd_flit[(m_ptr + k) % NCH][BW-1]) g = (m_ptr + k) % NCH;
                end
            end
            exp_rdy = (g >= 0) ? NCH'(1 << g) : '0;
            chk("rnd_rdy", 32'(r_ready_out), 32'(exp_rdy));
            chk("rnd_wreq", 32'(w_req), 32'(m_wreq));
            chk("rnd_data", 32'(data_o), 32'(m_data));
            next_cycle();
            if (!a_rst) begin
                m_wreq = 1'b0;
            end else if (g >= 0) begin
                m_ptr  = (g == NCH - 1) ? 0 : g + 1;
                m_data = snd_flit[g];
                m_wreq = 1'b1;
                snd_flit[g][BW-1] = 1'b0;
            end else begin
                m_wreq = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
